// File: rtl/axis_tx_scheduler.sv
// ---------------------------------------------------------------------------
// axis_tx_scheduler
//
// Shares one axis_master input stream between NUM_SRC packet producers. One
// source is granted at a time in round-robin order, exactly src_len beats are
// forwarded, and TLAST is generated on the final beat. axis_master has no
// ready on its input side, so a credit counter (occ) tracks its FIFO
// occupancy and beats are only accepted while the FIFO has room.
//
// Ports
//   M_AXIS_ACLK, M_AXIS_ARESETN : clock, async active-low reset
//   src_req   [NUM_SRC]         : packet request, held until src_done
//   src_len   [NUM_SRC*LEN]     : packet length in beats, sampled at grant
//   src_data  [NUM_SRC*W]       : beat data per source
//   src_valid [NUM_SRC]         : beat valid per source
//   src_ready [NUM_SRC]         : beat accept (at most one bit high)
//   src_done  [NUM_SRC]         : one-cycle pulse when a packet completes
//   TDATA_out/TVALID_out/TLAST_out : registered stream into axis_master
//   beat_pop                    : one axis_master FIFO entry drained
//   grant_id                    : current or last-granted source
//   busy                        : FSM not in IDLE
//   credit_err                  : sticky, beat_pop seen with occ == 0
//
// Handshake: a beat moves from source g exactly in the cycle where
// src_valid[g] and src_ready[g] are both high at the rising clock edge.
// src_ready does not depend on src_valid, and a source may raise src_valid
// before it is granted; the beat is simply not taken until src_ready is high.
// ---------------------------------------------------------------------------
module axis_tx_scheduler #(
  parameter int NUM_SRC              = 2,
  parameter int C_M_AXIS_TDATA_WIDTH = 32,
  parameter int FIFO_DEPTH           = 4,
  parameter int LEN_WIDTH            = 16
) (
  input  logic                                    M_AXIS_ACLK,
  input  logic                                    M_AXIS_ARESETN,
  input  logic [NUM_SRC-1:0]                      src_req,
  input  logic [NUM_SRC*LEN_WIDTH-1:0]            src_len,
  input  logic [NUM_SRC*C_M_AXIS_TDATA_WIDTH-1:0] src_data,
  input  logic [NUM_SRC-1:0]                      src_valid,
  output logic [NUM_SRC-1:0]                      src_ready,
  output logic [NUM_SRC-1:0]                      src_done,
  output logic [C_M_AXIS_TDATA_WIDTH-1:0]         TDATA_out,
  output logic                                    TVALID_out,
  output logic                                    TLAST_out,
  input  logic                                    beat_pop,
  output logic [$clog2(NUM_SRC)-1:0]              grant_id,
  output logic                                    busy,
  output logic                                    credit_err
);

  localparam int W  = C_M_AXIS_TDATA_WIDTH;
  localparam int GW = $clog2(NUM_SRC);
  localparam int OW = $clog2(FIFO_DEPTH + 1);
  localparam logic [OW-1:0] OCC_FULL = OW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_XFER = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [GW-1:0]        grant_q;
  logic [GW-1:0]        last_grant_q;
  logic [LEN_WIDTH-1:0] remain_q;
  logic [OW-1:0]        occ_q, occ_d;
  logic                 credit_err_q;
  logic                 tvalid_q;
  logic                 tlast_q;
  logic [W-1:0]         tdata_q;

  logic                 pick_valid;
  logic [GW-1:0]        pick_idx;
  logic [LEN_WIDTH-1:0] pick_len;
  logic                 sel_valid;
  logic [W-1:0]         sel_data;
  logic                 can_push;
  logic                 push;
  logic                 last_beat;

  // Round-robin pick: scan from last_grant+1 upward with wrap. The loop runs
  // from the farthest offset to the nearest so the nearest requester wins.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = last_grant_q;
    for (int k = NUM_SRC; k >= 1; k--) begin
      int idx;
      idx = (int'(last_grant_q) + k) % NUM_SRC;
      if (src_req[idx]) begin
        pick_valid = 1'b1;
        pick_idx   = GW'(idx);
      end
    end
  end

  assign pick_len  = src_len[int'(pick_idx)*LEN_WIDTH +: LEN_WIDTH];
  assign sel_valid = src_valid[grant_q];
  assign sel_data  = src_data[int'(grant_q)*W +: W];

  // Credit check uses the registered occupancy only, so a pop in the same
  // cycle never opens a slot until the following cycle.
  assign can_push  = (state_q == S_XFER) && (occ_q < OCC_FULL);
  assign push      = can_push && sel_valid;
  assign last_beat = (remain_q == LEN_WIDTH'(1));

  // State register
  always_ff @(posedge M_AXIS_ACLK or negedge M_AXIS_ARESETN) begin
    if (!M_AXIS_ARESETN) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (pick_valid) begin
          state_d = (pick_len != '0) ? S_XFER : S_DONE;
        end
      end
      S_XFER: begin
        if (push && last_beat) begin
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    src_ready = '0;
    src_done  = '0;
    src_ready[grant_q] = can_push;
    if (state_q == S_DONE) begin
      src_done[grant_q] = 1'b1;
    end
    busy = (state_q != S_IDLE);
  end

  // Occupancy: a push and a pop in the same cycle cancel. A pop on an empty
  // count cannot correspond to a real FIFO entry, so it is clamped at 0.
  always_comb begin
    occ_d = occ_q;
    unique case ({push, beat_pop})
      2'b10:   occ_d = occ_q + OW'(1);
      2'b01:   occ_d = (occ_q == '0) ? '0 : occ_q - OW'(1);
      default: occ_d = occ_q;
    endcase
  end

  // Datapath and bookkeeping registers
  always_ff @(posedge M_AXIS_ACLK or negedge M_AXIS_ARESETN) begin
    if (!M_AXIS_ARESETN) begin
      grant_q      <= '0;
      last_grant_q <= GW'(NUM_SRC - 1);
      remain_q     <= '0;
      occ_q        <= '0;
      credit_err_q <= 1'b0;
      tvalid_q     <= 1'b0;
      tlast_q      <= 1'b0;
      tdata_q      <= '0;
    end else begin
      if ((state_q == S_IDLE) && pick_valid) begin
        grant_q  <= pick_idx;
        remain_q <= pick_len;
      end else if (push) begin
        remain_q <= remain_q - LEN_WIDTH'(1);
      end
      if (state_q == S_DONE) begin
        last_grant_q <= grant_q;
      end
      occ_q <= occ_d;
      if (beat_pop && (occ_q == '0)) begin
        credit_err_q <= 1'b1;
      end
      tvalid_q <= push;
      tlast_q  <= push && last_beat;
      if (push) begin
        tdata_q <= sel_data;
      end
    end
  end

  assign TVALID_out = tvalid_q;
  assign TLAST_out  = tlast_q;
  assign TDATA_out  = tdata_q;
  assign grant_id   = grant_q;
  assign credit_err = credit_err_q;

endmodule

// File: doc/axis_tx_scheduler.md
# axis_tx_scheduler

Packet-level scheduler that shares the single `axis_master` output stream between `NUM_SRC` result producers (BNN layer/output engines). It grants one source at a time in round-robin order, forwards exactly the requested number of beats, and generates TLAST on the final beat. Because the `axis_master` input side has no ready, the block tracks `axis_master` FIFO occupancy with a credit counter so that it never overflows the FIFO. The block sits directly in front of `axis_master` and drives its `TDATA_in`, `TVALID_in` and `TLAST_in` inputs.

## Interface
- `NUM_SRC`, 2: number of requesters, ≥2.
- `C_M_AXIS_TDATA_WIDTH`, 32: beat width; must match `axis_master`.
- `FIFO_DEPTH`, 4: must equal the `axis_master` FIFO depth; sets the credit limit.
- `LEN_WIDTH`, 16: width of the packet length field, in beats.

- `M_AXIS_ACLK`, in, 1: clock.
- `M_AXIS_ARESETN`, in, 1: reset, asynchronous, active-low; shared with `axis_master`.
- `src_req`, in, NUM_SRC: packet request; held high until the matching `src_done`.
- `src_len`, in, NUM_SRC*LEN_WIDTH: packet length in beats; slice i belongs to source i; sampled at grant.
- `src_data`, in, NUM_SRC*C_M_AXIS_TDATA_WIDTH: beat data per source.
- `src_valid`, in, NUM_SRC: beat valid per source.
- `src_ready`, out, NUM_SRC: beat accept; at most one bit high.
- `src_done`, out, NUM_SRC: 1-cycle pulse when the packet completes.
- `TDATA_out`, out, C_M_AXIS_TDATA_WIDTH: connects to `axis_master.TDATA_in`.
- `TVALID_out`, out, 1: connects to `TVALID_in`.
- `TLAST_out`, out, 1: connects to `TLAST_in`.
- `beat_pop`, in, 1: `M_AXIS_TVALID & M_AXIS_TREADY` from `axis_master`, i.e. one FIFO entry drained.
- `grant_id`, out, $clog2(NUM_SRC): index of the current or last-granted source.
- `busy`, out, 1: high when the FSM is not in IDLE.
- `credit_err`, out, 1: sticky flag; set when `beat_pop` arrives while the occupancy count is 0.

## Operation
- **FSM states: IDLE, XFER, DONE.**
  - **IDLE:** if any `src_req` is high, select a source by round-robin, starting at `last_grant+1` and wrapping. Latch `grant_id` and `remain = src_len[g]`.
    - If `len != 0`, go to XFER.
    - If `len == 0`, go to DONE with no beats emitted.
  - **XFER:** `src_ready[g] = (occ < FIFO_DEPTH)`, using registered `occ`. A `beat_pop` in the same cycle does not raise the credit that cycle.
    - A push is `src_valid[g] & src_ready[g]`.
    - Each push decrements `remain`.
    - A push with `remain == 1` is the last beat; go to DONE.
  - **DONE:** pulse `src_done[g]`, set `last_grant = g`, go to IDLE.
- **Occupancy counter `occ`**, 0..FIFO_DEPTH:
  - push only: +1.
  - `beat_pop` only: −1.
  - push and `beat_pop` in the same cycle: unchanged.
  - `beat_pop` with `occ == 0`: `occ` stays 0 and `credit_err` is set.
- **Outputs are registered.** On each push, the next cycle shows:
  - `TVALID_out = 1`
  - `TDATA_out = src_data[g]`
  - `TLAST_out = (remain == 1)`

  In all other cycles `TVALID_out = 0` and `TLAST_out = 0`; `TDATA_out` holds its last value.
- Requests are sampled only in IDLE. A `src_req` that drops mid-packet is ignored and the packet still runs to length.
- While a packet is in progress, `src_valid` from non-granted sources is ignored.
- **Reset values:** all outputs 0; `occ = 0`; state IDLE; `last_grant = NUM_SRC-1`, so source 0 wins first; `credit_err = 0`.
- **Reset mid-packet:** the block aborts immediately and emits no TLAST. `axis_master` resets together with it, so `occ = 0` is consistent.

## Timing
- Grant latency: `src_req` seen in IDLE at cycle n → XFER at n+1, with `src_ready` high at n+1 if `occ < FIFO_DEPTH`.
- Data latency: a push at cycle k appears on `TVALID_out`/`TDATA_out` at k+1.
- Throughput: 1 beat/cycle while `occ` stays below `FIFO_DEPTH`. With `M_AXIS_TREADY` held at 1, `occ` settles at ≤2 and the packet streams without stalls.
- Inter-packet gap: the last push at k → `src_done` at k+1 (DONE) → IDLE at k+2 → next XFER at k+3.
- `len == 0`: IDLE → DONE → IDLE, with `src_done` 1 cycle after grant.

## Test plan
- **Single packet:** src0 `len = 4`, data 10..13, `TREADY = 1` → `TVALID_out` on 4 consecutive cycles with data 10..13. `TLAST_out` only with 13. `src_done[0]` is pulsed 1 cycle after the last push. `credit_err = 0`.
- **Backpressure:** `TREADY = 0`, src0 `len = 8` → exactly 4 pushes, then `src_ready[0] = 0` with `occ = 4`. After `TREADY = 1`, the remaining 4 beats flow. All 8 beats arrive in order with TLAST on beat 8.
- **Round-robin:** src0 and src1 both request continuously with `len = 2` → grant order 0,1,0,1. Each packet has TLAST on its 2nd beat, with a 2-cycle gap between packets.
- **Full with simultaneous pop:** `occ = 4` and `beat_pop = 1` in the same cycle → no push that cycle; `occ = 3` next cycle and `src_ready` reasserts.
- **Zero length:** src1 `len = 0` → no `TVALID_out`; `src_done[1]` pulses; the next grant goes to src0.
- **Reset mid-packet:** `M_AXIS_ARESETN` low after 3 of 6 beats → all outputs 0 and `occ = 0` immediately. After reset, a new src0 `len = 2` packet completes normally.
